// File: rtl/branch_redirect_ctrl.sv
// Jump-resolution sequencer: turns a resolved taken branch into a one-shot PC redirect
// followed by timed IF/ID + ID/EX flush pulses, and keeps saturating branch statistics.
module branch_redirect_ctrl #(
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 br_valid,
   input  logic                 br_taken,
   input  logic [PC_WIDTH-1:0]  br_target,
   input  logic                 cnt_clr,
   output logic                 pc_load,
   output logic [PC_WIDTH-1:0]  pc_next,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] taken_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [3:0]           FC_RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t               state_q, state_d;
   logic [3:0]           fcnt_q, fcnt_d;
   logic [PC_WIDTH-1:0]  pc_next_q, pc_next_d;
   logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
   logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
   logic                 pc_load_q, pc_load_d;
   logic                 flush_q, flush_d;
   logic                 busy_q, busy_d;
   logic                 accept;

   // Branch inputs are only looked at under accept, so don't-care values are harmless.
   assign accept = (state_q == IDLE) & br_valid & ~stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         fcnt_q        <= '0;
         pc_next_q     <= '0;
         br_count_q    <= '0;
         taken_count_q <= '0;
         pc_load_q     <= 1'b0;
         flush_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fcnt_q        <= fcnt_d;
         pc_next_q     <= pc_next_d;
         br_count_q    <= br_count_d;
         taken_count_q <= taken_count_d;
         pc_load_q     <= pc_load_d;
         flush_q       <= flush_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (!stall) begin
         case (state_q)
            IDLE: begin
               if (accept && br_taken) state_d = REDIRECT;
            end
            REDIRECT: begin
               if (FLUSH_CYCLES == 1) begin
                  state_d = IDLE;
               end else begin
                  state_d = FLUSH;
                  fcnt_d  = FC_RELOAD;
               end
            end
            FLUSH: begin
               fcnt_d = fcnt_q - 4'd1;
               if (fcnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so every output leaves a flop.
   always_comb begin
      pc_load_d     = (state_d == REDIRECT);
      flush_d       = (state_d != IDLE);
      busy_d        = (state_d != IDLE);
      pc_next_d     = pc_next_q;
      br_count_d    = br_count_q;
      taken_count_d = taken_count_q;
      if (accept) begin
         if (br_count_q != CNT_MAX) br_count_d = br_count_q + 1'b1;
         if (br_taken) begin
            pc_next_d = br_target;
            if (taken_count_q != CNT_MAX) taken_count_d = taken_count_q + 1'b1;
         end
      end
      if (cnt_clr) begin
         br_count_d    = '0;
         taken_count_d = '0;
      end
   end

   assign pc_load     = pc_load_q;
   assign pc_next     = pc_next_q;
   assign flush_ifid  = flush_q;
   assign flush_idex  = flush_q;
   assign busy        = busy_q;
   assign br_count    = br_count_q;
   assign taken_count = taken_count_q;

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the jump-resolution path. It takes the resolved branch outcome and target from the jump unit in the EX stage and produces a one-shot PC redirect to the fetch stage.
- Drives timed flush pulses into the IF/ID and ID/EX pipeline registers, and ignores wrong-path branches while the flush is in progress.
- Keeps saturating branch / taken-branch statistics counters for debug.

Parameters:
- PC_WIDTH, 32, width of the redirect target and pc_next.
- FLUSH_CYCLES, 2, total cycles flush_ifid/flush_idex stay high per taken branch (legal 1..15).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- stall  input  1  pipeline freeze from hazard/memory unit.
- br_valid  input  1  a branch instruction is resolved in EX this cycle.
- br_taken  input  1  resolved outcome; meaningful only with br_valid.
- br_target  input  PC_WIDTH  jump target; meaningful only with br_valid & br_taken.
- cnt_clr  input  1  synchronous clear of both statistics counters.
- pc_load  output  1  fetch PC must load pc_next.
- pc_next  output  PC_WIDTH  redirect target.
- flush_ifid  output  1  squash the IF/ID register.
- flush_idex  output  1  squash the ID/EX register.
- busy  output  1  controller is not in IDLE.
- br_count  output  CNT_WIDTH  number of accepted branches.
- taken_count  output  CNT_WIDTH  number of accepted taken branches.

Behaviour:
- All outputs are registered.
- Reset values (rst=0, async): state=IDLE, pc_load=0, pc_next=0, flush_ifid=0, flush_idex=0, busy=0, both counters=0, flush counter=0.
- States: IDLE, REDIRECT, FLUSH.
- Accept condition: state==IDLE & br_valid & ~stall. Branch inputs are sampled only under this condition.
- IDLE, accepted & br_taken:
  - capture br_target into pc_next;
  - next state REDIRECT;
  - br_count+1, taken_count+1.
- IDLE, accepted & ~br_taken:
  - br_count+1;
  - stay in IDLE; no redirect, no flush.
- REDIRECT (exactly 1 unstalled cycle):
  - pc_load=1, flush_ifid=1, flush_idex=1, busy=1.
  - If FLUSH_CYCLES==1, next state is IDLE.
  - Otherwise, next state is FLUSH with the flush counter loaded to FLUSH_CYCLES-1.
- FLUSH:
  - pc_load=0, flush_ifid=1, flush_idex=1, busy=1.
  - The counter decrements each unstalled cycle; at the cycle it reads 1, the next state is IDLE.
- Latency: the accepting edge is cycle 0. pc_load and the flushes are high from cycle 1. Flushes stay high for exactly FLUSH_CYCLES unstalled cycles. The next branch can be accepted in cycle FLUSH_CYCLES+1.
- br_valid while busy: the instruction is wrong-path. It is ignored and is not counted, including when br_taken=1.
- stall=1: state, flush counter, pc_next, counters and all outputs hold their current values. The stalled cycle does not count toward FLUSH_CYCLES. pc_load stays high through a stall in REDIRECT, and the fetch stage loads pc_next when the stall drops.
- Counters:
  - saturate at all-ones (no wrap);
  - cnt_clr=1 forces both to 0 and takes priority over a simultaneous increment;
  - cnt_clr acts regardless of stall and state, and does not affect the state machine.
- pc_next retains the last captured target after the redirect; only the next taken branch or reset changes it.
- Reset asserted mid-REDIRECT/FLUSH: outputs drop to their reset values immediately (asynchronously), without waiting for a clock edge. After rst deasserts, the controller starts in IDLE with no pending redirect.
- X-safety: br_taken and br_target are don't-care unless br_valid=1. A don't-care value must not change state or counters.

Test Plan:
- Reset, then br_valid=1, br_taken=1, br_target=0x0000_1234 for one cycle. Required: next cycle pc_load=1, pc_next=0x1234, flush_ifid=flush_idex=1. The flushes stay high 2 cycles total (default). IDLE is reached after that; br_count=1, taken_count=1.
- br_valid=1, br_taken=0 on 3 consecutive cycles. Required: no pc_load or flush at any point; br_count=3, taken_count=0, busy=0 throughout.
- Taken branch to 0x40, then br_valid=1, br_taken=1, br_target=0x80 in both flush cycles. Required: pc_next stays 0x40, exactly one pc_load pulse, br_count=1, taken_count=1.
- Taken branch, then stall=1 for 3 cycles starting in REDIRECT. Required: pc_load stays high for 4 cycles; the flushes total 5 cycles high (4 in REDIRECT + 1 FLUSH); the return to IDLE comes 3 cycles later than in the unstalled case.
- Preload br_count to all-ones via 65535 not-taken branches, then one more branch. Required: br_count stays 0xFFFF. Then assert cnt_clr together with br_valid=1, br_taken=1. Required: both counters read 0 next cycle, and a redirect still occurs.
- Drive rst=0 in the middle of a FLUSH cycle, between clock edges. Required: flush_ifid, flush_idex, pc_load, busy and pc_next drop to 0 before the next edge. After release, a new taken branch is accepted normally on the first cycle.
